// File: rtl/puf_challenge_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | puf_challenge_reader                                                     |
// | Applies one challenge to the serialized PUF and returns its response.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module puf_challenge_reader #(
    parameter int          TIMEOUT_CYCLES = 1 << 20,
    parameter int          ACK_CYCLES     = 2,
    parameter logic [31:0] ENABLE_MASK    = 32'hFFFF_FFFF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_challenge,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [7:0]  rsp_data,
    output logic        rsp_timeout,
    output logic        busy,
    output logic [7:0]  puf_challenge,
    output logic [31:0] puf_enable,
    output logic        puf_reset,
    input  logic        puf_done,
    input  logic [7:0]  puf_response
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ACK_W-1:0] C_ACK_LAST = ACK_W'(ACK_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACK  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           r_state;
    logic [ACK_W-1:0] r_ack_cnt;
    logic [CNT_W-1:0] r_to_cnt;

    // Reset gates readiness so a request presented during reset is never taken.
    assign req_ready = (r_state == S_IDLE) & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_ack_cnt     <= '0;
            r_to_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_data      <= 8'h00;
            rsp_timeout   <= 1'b0;
            busy          <= 1'b0;
            puf_challenge <= 8'h00;
            puf_enable    <= 32'h0;
            puf_reset     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        puf_challenge <= req_challenge;
                        r_ack_cnt     <= '0;
                        busy          <= 1'b1;
                        r_state       <= S_ACK;
                    end
                end
                S_ACK: begin
                    if (r_ack_cnt == C_ACK_LAST) begin
                        puf_reset  <= 1'b0;
                        puf_enable <= ENABLE_MASK;
                        r_to_cnt   <= '0;
                        r_state    <= S_WAIT;
                    end else begin
                        r_ack_cnt <= r_ack_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    // A done flag on the last count cycle still counts as a response.
                    if (puf_done) begin
                        rsp_data    <= puf_response;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= 1'b1;
                        puf_enable  <= 32'h0;
                        puf_reset   <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_to_cnt == C_TO_LAST) begin
                        rsp_data    <= 8'h00;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= 1'b1;
                        puf_enable  <= 32'h0;
                        puf_reset   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
